move_gen_seq: RTL
=================

MOVE_GEN_SEQ -- requirements
Module: move_gen_seq

Interface
REQ-001 BOARD_N, default 8; board side length, range 4..8; mask width is BOARD_N*BOARD_N.
REQ-002 CODE_W, default 4; piece code width.
REQ-003 clk  input  1  system clock, all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to generate moves; sampled only in IDLE.
REQ-006 piece  input  CODE_W  piece code: 0 empty; 1..6 white pawn, bishop, knight, rook, queen, king; 7..12 black in the same order.
REQ-007 pos_row, pos_col  input  3 each  square of the moving piece.
REQ-008 rd_row, rd_col  output  3 each  board square being examined.
REQ-009 rd_code  input  CODE_W  piece code at (rd_row, rd_col), valid in the same cycle.
REQ-010 target  input  6  square index row*BOARD_N+col for the legality query.
REQ-011 busy  output  1  high from accepted start until done.
REQ-012 done  output  1  one-cycle pulse; moves and target_ok are valid from this cycle on.
REQ-013 moves  output  BOARD_N*BOARD_N  reachable-square mask; bit index row*BOARD_N+col.
REQ-014 target_ok  output  1  equals moves[target] (combinational from the registered mask).

Function
REQ-015 The FSM SHALL have the states IDLE, SCAN, and DONE.
REQ-016 IDLE with start=1 and piece in 1..12: latch piece, position, and colour; clear moves; go to SCAN; set busy=1 from the next cycle.
REQ-017 IDLE with start=1 and piece 0 or 13..15: go straight to DONE; moves stays 0.
REQ-018 SCAN evaluates exactly one candidate per cycle, stepping from the piece along the current direction.
REQ-019 Direction sets:
- rook: +col, -col, +row, -row.
- bishop: four diagonals in the order (+r,+c), (+r,-c), (-r,+c), (-r,-c).
- queen: rook set, then bishop set.
- knight: (-2,-1), (-2,+1), (-1,-2), (-1,+2), (+1,-2), (+1,+2), (+2,-1), (+2,+1).
- king: all 8 unit offsets.
- pawn: forward, capture -col, capture +col; forward is +row for white, -row for black.
REQ-020 Rook, bishop, and queen SHALL slide; knight and king SHALL take one step per direction.
REQ-021 Sliding candidates:
- empty square: mark it and continue.
- enemy square: mark it and end the direction.
- own-colour square: do not mark; end the direction.
- off-board square: costs one cycle, no read, no mark; end the direction.
REQ-022 Step candidates are handled as in REQ-021, then the direction ends.
REQ-023 Pawn forward: mark only if empty.
- After one empty step, take a second step only if the start row is 1 (white) or BOARD_N-2 (black).
- An occupied or off-board square ends the direction unmarked.
REQ-024 Pawn capture: mark only an enemy square; one cycle per capture direction.
REQ-025 After the final candidate of the final direction, go to DONE; DONE lasts one cycle with done=1, then returns to IDLE with busy=0.
REQ-026 Latency from the start-accept edge to done equals the number of evaluated candidates plus 1.
REQ-027 start while busy or in DONE SHALL be ignored.
REQ-028 moves holds its value in IDLE until the next accepted start.
REQ-029 rd_row/rd_col SHALL be don't-care outside SCAN; bench may check only in SCAN.
REQ-030 Colour rule: white = 1..6, black = 7..12; code 0 is empty and is never own or enemy.
REQ-031 Position inputs ≥ BOARD_N SHALL produce done with moves = 0.

Reset
REQ-032 While rst=1, asynchronously: state=IDLE, busy=0, done=0, moves=0, all latched inputs=0.
REQ-033 Reset asserted during SCAN aborts the scan; no done pulse is produced for the aborted request.
REQ-034 After rst deasserts, the first rising edge with start=1 is accepted.

Verification
REQ-035 Empty board, BOARD_N=8, white rook (4) at (0,0) -> 18 evaluations; done 19 cycles after accept; moves = bits 1..7 and 8,16,...,56 set (14 bits).
REQ-036 White knight (3) at (0,0), empty board -> 8 evaluations; done at cycle 9; moves has only bits 10 and 17 set.
REQ-037 White pawn (1) at (1,4); board (2,3)=black rook (10), (2,5)=white knight (3), rest empty -> bits 20, 28, 19 set; bit 21 clear; target=28 gives target_ok=1.
REQ-038 Black bishop (8) at (3,3); (5,5)=black pawn (7), (1,1)=white pawn (1), rest empty -> bit 36 set, bit 45 clear, bit 9 set, bit 0 clear.
REQ-039 start during SCAN is ignored; rst pulsed mid-SCAN -> busy=0, moves=0 immediately, no done; a following start completes normally.

Source files
------------

// File: rtl/move_gen_seq.sv
// Sequential move generator: walks the direction set of one piece, one candidate
// square per cycle, and accumulates the reachable-square mask.
module move_gen_seq #(
  parameter int BOARD_N = 8,
  parameter int CODE_W  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [CODE_W-1:0]            piece,
  input  logic [2:0]                   pos_row,
  input  logic [2:0]                   pos_col,
  output logic [2:0]                   rd_row,
  output logic [2:0]                   rd_col,
  input  logic [CODE_W-1:0]            rd_code,
  input  logic [5:0]                   target,
  output logic                         busy,
  output logic                         done,
  output logic [BOARD_N*BOARD_N-1:0]   moves,
  output logic                         target_ok
);

  localparam int MW = BOARD_N * BOARD_N;
  localparam int IW = $clog2(MW);
  localparam logic signed [4:0] NS = 5'(BOARD_N);

  localparam logic [2:0] Z  = 3'b000;
  localparam logic [2:0] P1 = 3'b001;
  localparam logic [2:0] M1 = 3'b111;
  localparam logic [2:0] P2 = 3'b010;
  localparam logic [2:0] M2 = 3'b110;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef enum logic [2:0] {K_NONE, K_PAWN, K_BISHOP, K_KNIGHT, K_ROOK, K_QUEEN, K_KING} kind_t;

  state_t state, next_state;
  kind_t  kind, kind_in;
  logic   white, home;
  logic signed [4:0] base_r, base_c, cur_r, cur_c, cand_r, cand_c;
  logic [2:0] dir, last_dir;
  logic [5:0] off6;
  logic signed [2:0] dr, dc;
  logic slides, off_board, empty, enemy, mark, cont;
  logic rd_white, rd_black, pos_ok, in_white;
  logic [IW-1:0] idx;
  logic [6:0] tgt;

  function automatic logic [5:0] rook_off(input logic [1:0] d);
    case (d)
      2'd0: return {Z, P1};
      2'd1: return {Z, M1};
      2'd2: return {P1, Z};
      default: return {M1, Z};
    endcase
  endfunction

  function automatic logic [5:0] bishop_off(input logic [1:0] d);
    case (d)
      2'd0: return {P1, P1};
      2'd1: return {P1, M1};
      2'd2: return {M1, P1};
      default: return {M1, M1};
    endcase
  endfunction

  function automatic logic [5:0] knight_off(input logic [2:0] d);
    case (d)
      3'd0: return {M2, M1};
      3'd1: return {M2, P1};
      3'd2: return {M1, M2};
      3'd3: return {M1, P2};
      3'd4: return {P1, M2};
      3'd5: return {P1, P2};
      3'd6: return {P2, M1};
      default: return {P2, P1};
    endcase
  endfunction

  function automatic logic [5:0] king_off(input logic [2:0] d);
    case (d)
      3'd0: return {M1, M1};
      3'd1: return {M1, Z};
      3'd2: return {M1, P1};
      3'd3: return {Z, M1};
      3'd4: return {Z, P1};
      3'd5: return {P1, M1};
      3'd6: return {P1, Z};
      default: return {P1, P1};
    endcase
  endfunction

  // Piece decode at the request; codes outside 1..12 map to K_NONE.
  always_comb begin
    kind_in = K_NONE;
    case (piece)
      CODE_W'(1), CODE_W'(7):  kind_in = K_PAWN;
      CODE_W'(2), CODE_W'(8):  kind_in = K_BISHOP;
      CODE_W'(3), CODE_W'(9):  kind_in = K_KNIGHT;
      CODE_W'(4), CODE_W'(10): kind_in = K_ROOK;
      CODE_W'(5), CODE_W'(11): kind_in = K_QUEEN;
      CODE_W'(6), CODE_W'(12): kind_in = K_KING;
      default: kind_in = K_NONE;
    endcase
  end

  assign in_white = (piece <= CODE_W'(6));
  assign pos_ok   = ({1'b0, pos_row} < 4'(BOARD_N)) && ({1'b0, pos_col} < 4'(BOARD_N));

  always_comb begin
    off6     = '0;
    last_dir = 3'd7;
    slides   = 1'b0;
    case (kind)
      K_PAWN: begin
        last_dir = 3'd2;
        case (dir)
          3'd1:    off6 = {(white ? P1 : M1), M1};
          3'd2:    off6 = {(white ? P1 : M1), P1};
          default: off6 = {(white ? P1 : M1), Z};
        endcase
      end
      K_BISHOP: begin
        last_dir = 3'd3;
        slides   = 1'b1;
        off6     = bishop_off(dir[1:0]);
      end
      K_KNIGHT: off6 = knight_off(dir);
      K_ROOK: begin
        last_dir = 3'd3;
        slides   = 1'b1;
        off6     = rook_off(dir[1:0]);
      end
      K_QUEEN: begin
        slides = 1'b1;
        off6   = dir[2] ? bishop_off(dir[1:0]) : rook_off(dir[1:0]);
      end
      K_KING: off6 = king_off(dir);
      default: off6 = '0;
    endcase
  end

  assign dr = off6[5:3];
  assign dc = off6[2:0];
  assign cand_r = cur_r + $signed({{2{dr[2]}}, dr});
  assign cand_c = cur_c + $signed({{2{dc[2]}}, dc});
  assign off_board = (cand_r < 5'sd0) || (cand_r >= NS) || (cand_c < 5'sd0) || (cand_c >= NS);
  assign rd_row = cand_r[2:0];
  assign rd_col = cand_c[2:0];

  assign rd_white = (rd_code >= CODE_W'(1)) && (rd_code <= CODE_W'(6));
  assign rd_black = (rd_code >= CODE_W'(7)) && (rd_code <= CODE_W'(12));
  assign empty    = (rd_code == '0);
  assign enemy    = white ? rd_black : rd_white;

  // Pawn forward only advances a second square from the home row; captures never continue.
  always_comb begin
    mark = 1'b0;
    cont = 1'b0;
    if (!off_board) begin
      if (kind == K_PAWN && dir == 3'd0) begin
        mark = empty;
        cont = empty && home && (cur_r == base_r) && (cur_c == base_c);
      end else if (kind == K_PAWN) begin
        mark = enemy;
      end else begin
        mark = empty || enemy;
        cont = slides && empty;
      end
    end
  end

  assign idx = IW'(cand_r[2:0]) * IW'(BOARD_N) + IW'(cand_c[2:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = (kind_in != K_NONE && pos_ok) ? SCAN : DONE;
      SCAN: if (!cont && dir == last_dir) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      moves  <= '0;
      kind   <= K_NONE;
      white  <= 1'b0;
      home   <= 1'b0;
      base_r <= '0;
      base_c <= '0;
      cur_r  <= '0;
      cur_c  <= '0;
      dir    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          moves  <= '0;
          kind   <= pos_ok ? kind_in : K_NONE;
          white  <= in_white;
          home   <= in_white ? (pos_row == 3'd1) : (pos_row == 3'(BOARD_N - 2));
          base_r <= {2'b00, pos_row};
          base_c <= {2'b00, pos_col};
          cur_r  <= {2'b00, pos_row};
          cur_c  <= {2'b00, pos_col};
          dir    <= '0;
        end
        SCAN: begin
          if (mark) moves[idx] <= 1'b1;
          if (cont) begin
            cur_r <= cand_r;
            cur_c <= cand_c;
          end else begin
            cur_r <= base_r;
            cur_c <= base_c;
            dir   <= dir + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign tgt  = {1'b0, target};
  assign target_ok = (tgt < 7'(MW)) ? moves[target[IW-1:0]] : 1'b0;

endmodule
